uart_rx_apb_ctrl: RTL and testbench
===================================

# uart_rx_apb_ctrl

Receive-side controller for the UART receiver: captures each completed byte from the receive datapath into a small FIFO, exposes control, status and data registers on the APB slave bus of the RISC-V peripheral subsystem, and raises a level interrupt. It decides when bytes are accepted, dropped or flushed, and when software is notified.

## Interface
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64
- TIMEOUT_TICKS, 512, idle baud-tick count before the timeout flag sets (only with RX_TIMEOUT_EN)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high; clock clk
- rx_done  in  1  one-cycle strobe: byte complete from receiver
- rx_data  in  8  received byte, valid with rx_done
- tick  in  1  16x baud tick, one clk wide
- PADDR  in  4  byte address; bits [1:0] ignored
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  transfer complete
- irq  out  1  level interrupt, registered

## Operation
- Registers: 0x0 CTRL (RW): [0] enable, [1] irq_en, [2] flush (write-1, self-clearing, reads 0), [7:4] threshold (0 treated as 1). 0x4 STATUS: [0] empty, [1] full, [2] overrun (sticky, W1C), [3] timeout (sticky, W1C), [14:8] count. 0x8 RDATA (RO): [7:0] FIFO head; read pops. Other addresses read 0, writes ignored.
- Push: rx_done & enable. When full and no pop in the same cycle, the byte is dropped and overrun sets. When enable=0, rx_done is ignored with no flag change.
- Pop: completed APB read of 0x8. When empty, the read returns 0 and FIFO state is unchanged.
- Simultaneous push and pop: both occur and count is unchanged. This holds when full: the byte is accepted and overrun does not set.
- Flush: resets pointers and count to 0 and clears the timeout counter. A push in the same cycle is discarded. Sticky flags are not cleared.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits and saturates at FIFO_DEPTH.
- irq_next = irq_en & ((count >= threshold) | overrun | timeout).

## Timing
- APB: one wait-free access. PRDATA is loaded in the setup cycle (PSEL & ~PENABLE) with the addressed register's current value. PREADY = 1 in the access cycle (PSEL & PENABLE), otherwise 0.
- Writes and pops take effect at the clock edge ending the access cycle.
- Push is visible in STATUS on the cycle after rx_done.
- irq updates one clk after its causing condition.
- Reset values: PRDATA 0, PREADY 0, irq 0. Internally: CTRL 0, pointers 0, count 0, flags 0, timeout counter 0.
- Reset mid-transfer: the access aborts, FIFO contents are lost, and no pop is performed.

## Configuration
- RX_TIMEOUT_EN defined: a counter increments on tick while count > 0 and is cleared on every push, pop or flush. At TIMEOUT_TICKS it sets timeout, then holds until cleared.
- RX_TIMEOUT_EN undefined: no counter is built, STATUS[3] reads 0, and timeout does not contribute to irq.

## Test plan
- After reset, read 0x4 → 0x0000_0001 (empty). PREADY is high only in the access cycle.
- Set CTRL=0x23 (enable, irq_en, threshold 2). Push 0x41, then push 0x42. irq rises one clk after the second push. Reading 0x8 returns 0x41, then 0x42, and irq drops.
- With FIFO_DEPTH=8, push 9 bytes 0x00..0x08. STATUS reads full=1, overrun=1, count=8. Reads return 0x00..0x07. Writing 0x4 with 0x4 clears overrun.
- With the FIFO full, pulse rx_done=0x55 in the same cycle a 0x8 read completes. Count stays 8, overrun stays 0, and 0x55 is the last byte read out.
- Push 3 bytes, then write CTRL with bit2 set, pushing 0x77 in that cycle. STATUS reads 0x0000_0001 and the next 0x8 read returns 0.
- With RX_TIMEOUT_EN defined: push 1 byte, then supply 512 ticks with no other activity. timeout sets and irq=1. Without the macro, STATUS[3] stays 0.

Source files
------------

// File: rtl/uart_rx_apb_ctrl.sv
// UART receive controller: byte FIFO, APB CTRL/STATUS/RDATA registers, level irq.
// Optional build macro RX_TIMEOUT_EN adds the idle-tick timeout flag (STATUS[3]).
module uart_rx_apb_ctrl #(
   parameter int FIFO_DEPTH    = 8,
   parameter int TIMEOUT_TICKS = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   input  logic        tick,
   input  logic [3:0]  PADDR,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic            enable;
   logic            irq_en;
   logic [3:0]      threshold;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            overrun;
   logic            timeout;

   logic            setup;
   logic            access;
   logic [1:0]      reg_sel;
   logic            empty;
   logic            full;
   logic            wr_ctrl;
   logic            wr_stat;
   logic            flush;
   logic            pop;
   logic            push_req;
   logic            push;
   logic            drop;
   logic [3:0]      thr_eff;
   logic [31:0]     rd_val;
   logic            unused_bits;

   assign setup    = PSEL & ~PENABLE;
   assign access   = PSEL & PENABLE;
   assign reg_sel  = PADDR[3:2];
   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign wr_ctrl  = access & PWRITE & (reg_sel == 2'd0);
   assign wr_stat  = access & PWRITE & (reg_sel == 2'd1);
   assign flush    = wr_ctrl & PWDATA[2];
   // A pop of an empty FIFO is suppressed so state stays unchanged.
   assign pop      = access & ~PWRITE & (reg_sel == 2'd2) & ~empty;
   // A flush in the same cycle discards the incoming byte.
   assign push_req = rx_done & enable & ~flush;
   // When full, a same-cycle pop frees the slot so the byte is still accepted.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;
   assign thr_eff  = (threshold == 4'd0) ? 4'd1 : threshold;

   // Register read mux feeding PRDATA in the setup cycle.
   always_comb begin
      rd_val = '0;
      case (reg_sel)
         2'd0: rd_val = {24'd0, threshold, 2'b00, irq_en, enable};
         2'd1: rd_val = {17'd0, 7'(count), 4'd0, timeout, overrun, full, empty};
         2'd2: rd_val = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
         default: rd_val = '0;
      endcase
   end

   // APB response: PRDATA captured in setup, PREADY high for the access cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PRDATA <= '0;
         PREADY <= 1'b0;
      end else begin
         PREADY <= setup;
         if (setup) PRDATA <= rd_val;
      end
   end

   // CTRL register; flush is a strobe and is not stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         threshold <= '0;
      end else if (wr_ctrl) begin
         enable    <= PWDATA[0];
         irq_en    <= PWDATA[1];
         threshold <= PWDATA[7:4];
      end
   end

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_data;
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push & ~pop)      count <= count + CW'(1);
         else if (pop & ~push) count <= count - CW'(1);
      end
   end

   // Sticky overrun flag; a new drop wins over a same-cycle W1C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= 1'b0;
      else     overrun <= (overrun & ~(wr_stat & PWDATA[2])) | drop;
   end

`ifdef RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] to_cnt;
   logic          activity;
   logic          to_step;

   assign activity = flush | push | pop;
   assign to_step  = tick & ~empty & ~activity & (to_cnt != TW'(TIMEOUT_TICKS));

   // Idle-tick counter saturating at TIMEOUT_TICKS; sets the sticky timeout flag on arrival.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (activity)     to_cnt <= '0;
         else if (to_step) to_cnt <= to_cnt + TW'(1);
         timeout <= (timeout & ~(wr_stat & PWDATA[3])) |
                    (to_step & (to_cnt == TW'(TIMEOUT_TICKS - 1)));
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign unused_bits = ^{PADDR[1:0], PWDATA[31:8], PWDATA[3], tick};

   // Registered level interrupt from current occupancy and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= irq_en & ((8'(count) >= {4'd0, thr_eff}) | overrun | timeout);
   end
endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// Scoreboard bench for uart_rx_apb_ctrl: queue-based reference model, directed and random phases.
module tb_uart_rx_apb_ctrl;
   localparam int DEPTH = 8;
   localparam int TICKS = 512;
`ifdef RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        tick = 1'b0;
   logic [3:0]  PADDR = '0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0]  mq[$];
   logic [31:0] exp_q[$];
   bit          m_en, m_irqen, m_ovr, m_to;
   logic [3:0]  m_thr;
   int          m_idle;

   uart_rx_apb_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_TICKS(TICKS)) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .tick(tick),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
      end
   endtask

   // Monitor: compare every completed read against the queued expectation.
   always @(negedge clk) begin
      if (!rst && PSEL) chk("pready_phase", {31'd0, PREADY}, {31'd0, PENABLE});
      if (!rst && PSEL && PENABLE && PREADY && !PWRITE) begin
         if (exp_q.size() == 0) chk("unexpected_read", PRDATA, 32'hDEAD_BEEF);
         else chk("prdata", PRDATA, exp_q.pop_front());
      end
   end

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0: return {24'd0, m_thr, 2'b00, m_irqen, m_en};
         2'd1: return {17'd0, 7'(mq.size()), 4'd0, m_to, m_ovr, mq.size() == DEPTH, mq.size() == 0};
         2'd2: return (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit model_irq();
      int thr = (m_thr == 0) ? 1 : int'(m_thr);
      return m_irqen && ((mq.size() >= thr) || m_ovr || m_to);
   endfunction

   // Effect of one clock edge on the FIFO model: pop first, then the incoming byte.
   task automatic model_edge(input bit rxd, input logic [7:0] d, input bit do_pop, input bit do_flush);
      if (do_pop && mq.size() > 0) begin
         void'(mq.pop_front());
         m_idle = 0;
      end
      if (rxd && m_en && !do_flush) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(d);
            m_idle = 0;
         end else m_ovr = 1;
      end
      if (do_flush) begin
         mq.delete();
         m_idle = 0;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_en = 0; m_irqen = 0; m_ovr = 0; m_to = 0; m_thr = 0; m_idle = 0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(posedge clk); #1;
      rx_done = 1'b1; rx_data = d;
      @(posedge clk);
      model_edge(1'b1, d, 1'b0, 1'b0);
      #1 rx_done = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, input bit rxd, input logic [7:0] d);
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      exp_q.push_back(model_read(a));
      @(posedge clk); #1;
      PENABLE = 1'b1; rx_done = rxd; rx_data = d;
      @(posedge clk);
      model_edge(rxd, d, a[3:2] == 2'd2, 1'b0);
      #1 PSEL = 1'b0; PENABLE = 1'b0; rx_done = 1'b0;
   endtask

   task automatic apb_write(input logic [3:0] a, input logic [31:0] v, input bit rxd, input logic [7:0] d);
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = v;
      @(posedge clk); #1;
      PENABLE = 1'b1; rx_done = rxd; rx_data = d;
      @(posedge clk);
      if (a[3:2] == 2'd0) begin
         model_edge(rxd, d, 1'b0, v[2]);
         m_en = v[0]; m_irqen = v[1]; m_thr = v[7:4];
      end else begin
         model_edge(rxd, d, 1'b0, 1'b0);
         if (a[3:2] == 2'd1) begin
            if (v[2]) m_ovr = 0;
            if (v[3]) m_to = 0;
         end
      end
      #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rx_done = 1'b0;
   endtask

   task automatic give_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 tick = 1'b1;
         @(posedge clk);
         if (TO_EN && mq.size() > 0 && m_idle < TICKS) begin
            m_idle++;
            if (m_idle == TICKS) m_to = 1;
         end
         #1 tick = 1'b0;
      end
   endtask

   task automatic check_irq(input string name);
      @(posedge clk); @(negedge clk);
      chk(name, {31'd0, irq}, {31'd0, model_irq()});
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_prdata", PRDATA, 32'd0);
      chk("reset_pready", {31'd0, PREADY}, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;

      // status after reset: empty only
      apb_read(4'h4, 0, 0);

      // threshold-2 interrupt
      apb_write(4'h0, 32'h23, 0, 0);
      apb_read(4'h0, 0, 0);
      push_byte(8'h41);
      check_irq("irq_one_byte");
      push_byte(8'h42);
      @(negedge clk);
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("irq_after_two", {31'd0, irq}, 32'd1);
      apb_read(4'h8, 0, 0);
      check_irq("irq_drops");
      apb_read(4'h8, 0, 0);
      apb_read(4'h8, 0, 0);

      // overflow
      for (int i = 0; i < 9; i++) push_byte(8'(i));
      apb_read(4'h4, 0, 0);
      check_irq("irq_overrun");
      for (int i = 0; i < 8; i++) apb_read(4'h8, 0, 0);
      apb_write(4'h4, 32'h4, 0, 0);
      apb_read(4'h4, 0, 0);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
      apb_read(4'h8, 1, 8'h55);
      apb_read(4'h4, 0, 0);
      for (int i = 0; i < 8; i++) apb_read(4'h8, 0, 0);

      // flush discards a same-cycle push
      for (int i = 0; i < 3; i++) push_byte(8'hA0 + 8'(i));
      apb_write(4'h0, 32'h27, 1, 8'h77);
      apb_read(4'h4, 0, 0);
      apb_read(4'h8, 0, 0);
      apb_read(4'hC, 0, 0);

      // idle timeout
      push_byte(8'h99);
      give_ticks(TICKS - 1);
      apb_read(4'h4, 0, 0);
      check_irq("irq_before_timeout");
      give_ticks(1);
      apb_read(4'h4, 0, 0);
      check_irq("irq_timeout");
      apb_write(4'h4, 32'h8, 0, 0);
      apb_write(4'h0, 32'h27, 0, 0);
      apb_read(4'h4, 0, 0);

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         int op = $urandom_range(0, 9);
         logic [7:0] b = 8'($urandom);
         case (op)
            0, 1, 2: push_byte(b);
            3: apb_read(4'h4, 0, 0);
            4, 5: apb_read(4'h8, 0, 0);
            6: apb_read(4'h8, 1, b);
            7: begin
               logic [31:0] v = $urandom;
               v[0] = ($urandom_range(0, 3) != 0);
               v[2] = ($urandom_range(0, 3) == 0);
               apb_write(4'h0, v, $urandom_range(0, 1), b);
            end
            8: apb_write(4'h4, $urandom, 0, 0);
            default: begin
               apb_write(4'hC, $urandom, 0, 0);
               apb_read(4'h0, 0, 0);
            end
         endcase
         check_irq("irq_random");
      end

      // asynchronous reset clears everything
      push_byte(8'h5A);
      #3 rst = 1'b1;
      #1 chk("async_reset_prdata", PRDATA, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      apb_read(4'h4, 0, 0);
      apb_read(4'h0, 0, 0);

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
